// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: fetch PC, wait-state tolerant imem interface,
// DEPTH-entry {pc, inst} queue and prioritised exc / irq / redirect handling
// with kernel-mode protection on PC bit WIDTH-1.
module fetch_queue_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h8000_0000,
  parameter logic [WIDTH-1:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [WIDTH-1:0]         imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     imem_valid,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  input  logic                     irq,
  input  logic                     exc,
  input  logic                     deq,
  output logic                     q_valid,
  output logic [31:0]              q_inst,
  output logic [WIDTH-1:0]         q_pc,
  output logic [WIDTH-1:0]         epc,
  output logic                     kernel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    EV_SEQ,
    EV_REDIR,
    EV_IRQ,
    EV_EXC
  } event_e;

  logic [WIDTH-1:0] r_fpc;
  logic [WIDTH-1:0] r_epc;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [31:0]      r_mem_inst [DEPTH];

  logic             w_q_valid;
  logic [WIDTH-1:0] w_head_pc;
  logic [31:0]      w_head_inst;
  logic             w_kernel;
  logic             w_irq_taken;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ret_pc;
  logic [WIDTH-1:0] w_redir_pc;
  logic [WIDTH-1:0] w_fpc_inc;
  event_e           w_event;

  assign w_q_valid   = (r_count != '0);
  assign w_head_pc   = w_q_valid ? r_mem_pc[r_rd_ptr]   : '0;
  assign w_head_inst = w_q_valid ? r_mem_inst[r_rd_ptr] : '0;

  // Mode follows the oldest unexecuted instruction, else the fetch PC.
  assign w_kernel    = w_q_valid ? w_head_pc[WIDTH-1] : r_fpc[WIDTH-1];
  assign w_irq_taken = irq & ~w_kernel;
  assign w_full      = (r_count == CW'(DEPTH));

  // Return address is the oldest instruction that has not been executed.
  assign w_ret_pc    = w_q_valid ? w_head_pc : r_fpc;

  // User-mode redirects cannot raise the kernel bit; targets are word aligned.
  assign w_redir_pc  = {w_kernel & redirect_pc[WIDTH-1],
                        redirect_pc[WIDTH-2:0] & ~(WIDTH-1)'(3)};

  // Sequential increment wraps within the low WIDTH-1 bits; mode bit is held.
  assign w_fpc_inc   = {r_fpc[WIDTH-1], r_fpc[WIDTH-2:0] + (WIDTH-1)'(4)};

  // Per-cycle event priority: exc > taken irq > redirect > sequential fetch.
  always_comb begin
    w_event = EV_SEQ;
    if (exc)              w_event = EV_EXC;
    else if (w_irq_taken) w_event = EV_IRQ;
    else if (redirect)    w_event = EV_REDIR;
  end

  // A full queue may still accept a fetch when the head is popped in the same cycle.
  assign w_push = (w_event == EV_SEQ) & imem_valid & (~w_full | deq);
  assign w_pop  = (w_event == EV_SEQ) & deq & w_q_valid;

  // Fetch PC, queue pointers/occupancy and saved return address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fpc    <= RESET_VEC;
      r_epc    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      unique case (w_event)
        EV_EXC: begin
          r_fpc    <= EXC_VEC;
          r_epc    <= w_ret_pc;
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
          r_count  <= '0;
        end
        EV_IRQ: begin
          r_fpc    <= IRQ_VEC;
          r_epc    <= w_ret_pc;
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
          r_count  <= '0;
        end
        EV_REDIR: begin
          r_fpc    <= w_redir_pc;
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
          r_count  <= '0;
        end
        default: begin
          if (w_push) begin
            r_fpc    <= w_fpc_inc;
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
          end
          unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      endcase
    end
  end

  // Queue storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_fpc;
      r_mem_inst[r_wr_ptr] <= imem_data;
    end
  end

  assign imem_addr = {1'b0, r_fpc[WIDTH-2:0]};
  assign q_valid   = w_q_valid;
  assign q_pc      = w_head_pc;
  assign q_inst    = w_head_inst;
  assign epc       = r_epc;
  assign kernel    = w_kernel;
  assign count     = r_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: table-driven fill/stream vectors
// with a scoreboard of fetched {pc, inst}, plus hand-written event sequences.
module tb_fetch_queue_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq;
  logic        exc;
  logic        deq;
  logic        q_valid;
  logic [31:0] q_inst;
  logic [31:0] q_pc;
  logic [31:0] epc;
  logic        kernel;
  logic [2:0]  count;

  int unsigned n_chk;
  int unsigned n_fail;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    logic        v;
    logic        d;
    int unsigned exp_count;
    logic [31:0] exp_addr;
  } vec_t;

  entry_t      sb[$];
  vec_t        vecs[17];
  logic [31:0] exp_fpc;

  fetch_queue_unit #(
    .WIDTH    (32),
    .DEPTH    (4),
    .RESET_VEC(32'h8000_0000),
    .IRQ_VEC  (32'h8000_0004),
    .EXC_VEC  (32'h8000_0008)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .irq        (irq),
    .exc        (exc),
    .deq        (deq),
    .q_valid    (q_valid),
    .q_inst     (q_inst),
    .q_pc       (q_pc),
    .epc        (epc),
    .kernel     (kernel),
    .count      (count)
  );

  // Instruction ROM model: content is a function of the fetch address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  assign imem_data = rom(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_valid  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    irq         = 1'b0;
    exc         = 1'b0;
    deq         = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // {imem_valid, deq, expected count, expected imem_addr} after each edge
    vecs[0]  = '{1'b1, 1'b0, 1, 32'h0000_0004};
    vecs[1]  = '{1'b1, 1'b0, 2, 32'h0000_0008};
    vecs[2]  = '{1'b1, 1'b0, 3, 32'h0000_000C};
    vecs[3]  = '{1'b1, 1'b0, 4, 32'h0000_0010};
    vecs[4]  = '{1'b1, 1'b0, 4, 32'h0000_0010};
    vecs[5]  = '{1'b1, 1'b0, 4, 32'h0000_0010};
    vecs[6]  = '{1'b1, 1'b1, 4, 32'h0000_0014};
    vecs[7]  = '{1'b1, 1'b1, 4, 32'h0000_0018};
    vecs[8]  = '{1'b1, 1'b1, 4, 32'h0000_001C};
    vecs[9]  = '{1'b0, 1'b1, 3, 32'h0000_001C};
    vecs[10] = '{1'b1, 1'b0, 4, 32'h0000_0020};
    vecs[11] = '{1'b0, 1'b1, 3, 32'h0000_0020};
    vecs[12] = '{1'b0, 1'b1, 2, 32'h0000_0020};
    vecs[13] = '{1'b0, 1'b1, 1, 32'h0000_0020};
    vecs[14] = '{1'b0, 1'b1, 0, 32'h0000_0020};
    vecs[15] = '{1'b0, 1'b1, 0, 32'h0000_0020};
    vecs[16] = '{1'b1, 1'b1, 1, 32'h0000_0024};

    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk("rst_count",  32'(count),   32'd0);
    chk("rst_qvalid", 32'(q_valid), 32'd0);
    chk("rst_qpc",    q_pc,         32'h0);
    chk("rst_qinst",  q_inst,       32'h0);
    chk("rst_epc",    epc,          32'h0);
    chk("rst_kernel", 32'(kernel),  32'd1);
    chk("rst_addr",   imem_addr,    32'h0);

    // Fill, full stall, streaming with push+pop, drain, deq-while-empty
    reset   = 1'b1;
    exp_fpc = 32'h8000_0000;
    for (int unsigned i = 0; i < 17; i++) begin
      logic do_push;
      logic do_pop;
      imem_valid = vecs[i].v;
      deq        = vecs[i].d;
      do_pop     = vecs[i].d && (sb.size() > 0);
      do_push    = vecs[i].v && ((sb.size() < 4) || vecs[i].d);
      if (do_pop) begin
        chk($sformatf("pop_pc[%0d]", i),   q_pc,   sb[0].pc);
        chk($sformatf("pop_inst[%0d]", i), q_inst, sb[0].inst);
        void'(sb.pop_front());
      end
      if (do_push) begin
        sb.push_back('{exp_fpc, rom({1'b0, exp_fpc[30:0]})});
        exp_fpc = {exp_fpc[31], exp_fpc[30:0] + 31'd4};
      end
      tick();
      chk($sformatf("count[%0d]", i),  32'(count),   32'(vecs[i].exp_count));
      chk($sformatf("addr[%0d]", i),   imem_addr,    vecs[i].exp_addr);
      chk($sformatf("qvalid[%0d]", i), 32'(q_valid), 32'(vecs[i].exp_count != 0));
      if (sb.size() > 0) chk($sformatf("head_pc[%0d]", i), q_pc, sb[0].pc);
      else               chk($sformatf("head_pc[%0d]", i), q_pc, 32'h0);
    end

    // Kernel-mode redirect keeps the kernel bit; push and deq discarded
    redirect    = 1'b1;
    redirect_pc = 32'h8000_1237;
    imem_valid  = 1'b1;
    deq         = 1'b1;
    tick();
    sb.delete();
    chk("kredir_count",  32'(count),  32'd0);
    chk("kredir_addr",   imem_addr,   32'h0000_1234);
    chk("kredir_kernel", 32'(kernel), 32'd1);
    imem_valid  = 1'b0;
    deq         = 1'b0;
    redirect_pc = 32'h0000_0040;
    tick();
    chk("to_user_kernel", 32'(kernel), 32'd0);
    chk("to_user_addr",   imem_addr,   32'h0000_0040);
    redirect_pc = 32'h8000_1237;
    tick();
    chk("uredir_addr",   imem_addr,   32'h0000_1234);
    chk("uredir_kernel", 32'(kernel), 32'd0);

    // User-mode irq with head at 0x40, then level irq held in kernel mode
    redirect_pc = 32'h0000_0040;
    tick();
    redirect   = 1'b0;
    imem_valid = 1'b1;
    tick();
    tick();
    chk("pre_irq_qpc",    q_pc,        32'h0000_0040);
    chk("pre_irq_kernel", 32'(kernel), 32'd0);
    imem_valid = 1'b0;
    irq        = 1'b1;
    tick();
    chk("irq_count",  32'(count),  32'd0);
    chk("irq_addr",   imem_addr,   32'h0000_0004);
    chk("irq_epc",    epc,         32'h0000_0040);
    chk("irq_kernel", 32'(kernel), 32'd1);
    imem_valid = 1'b1;
    tick();
    tick();
    chk("irq_hold_count", 32'(count), 32'd2);
    chk("irq_hold_addr",  imem_addr,  32'h0000_000C);
    chk("irq_hold_epc",   epc,        32'h0000_0040);
    chk("irq_hold_qpc",   q_pc,       32'h8000_0004);
    imem_valid  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("ret_user_count",  32'(count),  32'd0);
    chk("ret_user_kernel", 32'(kernel), 32'd0);
    chk("ret_user_addr",   imem_addr,   32'h0000_0100);
    tick();
    chk("reirq_addr",   imem_addr,   32'h0000_0004);
    chk("reirq_epc",    epc,         32'h0000_0100);
    chk("reirq_kernel", 32'(kernel), 32'd1);
    irq = 1'b0;

    // All events at once in user mode: exc wins
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect   = 1'b0;
    imem_valid = 1'b1;
    tick();
    tick();
    chk("pre_exc_qpc",   q_pc,       32'h0000_0300);
    chk("pre_exc_count", 32'(count), 32'd2);
    exc         = 1'b1;
    irq         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    deq         = 1'b1;
    imem_valid  = 1'b1;
    tick();
    clear_inputs();
    chk("exc_addr",   imem_addr,   32'h0000_0008);
    chk("exc_count",  32'(count),  32'd0);
    chk("exc_epc",    epc,         32'h0000_0300);
    chk("exc_kernel", 32'(kernel), 32'd1);

    // imem_valid 1,0,1: two pushes, fpc advances by 8
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    chk("wait_count", 32'(count), 32'd2);
    chk("wait_addr",  imem_addr,  32'h0000_0010);
    chk("wait_qpc",   q_pc,       32'h8000_0008);
    chk("wait_qinst", q_inst,     rom(32'h0000_0008));

    // Asynchronous reset mid-cycle while streaming
    imem_valid = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    chk("arst_count",  32'(count),   32'd0);
    chk("arst_qvalid", 32'(q_valid), 32'd0);
    chk("arst_epc",    epc,          32'h0);
    chk("arst_addr",   imem_addr,    32'h0);
    chk("arst_qpc",    q_pc,         32'h0);
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation MIPS core.
- It replaces the single-register PC / next-PC mux with four pieces:
  - a fetch PC register;
  - an instruction-memory interface that tolerates wait states;
  - a DEPTH-entry instruction queue decoupling fetch from decode;
  - prioritised exception / interrupt / redirect handling, with kernel-mode protection on PC bit WIDTH-1.
- Sits between the instruction ROM and the decode/control stage.

Parameters:
- WIDTH, 32, address/PC width; bit WIDTH-1 is the kernel bit.
- DEPTH, 4, instruction queue entries (power of 2, >=2).
- RESET_VEC, 32'h80000000, PC after reset.
- IRQ_VEC, 32'h80000004, interrupt entry address.
- EXC_VEC, 32'h80000008, exception entry address.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  WIDTH  fetch address = {1'b0, fpc[WIDTH-2:0]}.
- imem_data  in  32  instruction at imem_addr.
- imem_valid  in  1  imem_data valid this cycle (ROM wait-state support).
- redirect  in  1  taken branch / jump / jr from downstream.
- redirect_pc  in  WIDTH  redirect target.
- irq  in  1  level interrupt request from peripherals.
- exc  in  1  exception from decode (undefined instruction).
- deq  in  1  consumer pops the queue head.
- q_valid  out  1  queue non-empty.
- q_inst  out  32  head instruction.
- q_pc  out  WIDTH  head instruction address.
- epc  out  WIDTH  saved return address of the last irq/exc.
- kernel  out  1  current mode (1 = kernel).
- count  out  clog2(DEPTH)+1  queue occupancy.

Behaviour:

State:
- fpc (WIDTH), circular queue of {pc, inst} with rd/wr pointers, count, epc.

Reset (reset=0, asynchronous):
- fpc=RESET_VEC, count=0, pointers=0, epc=0.
- Outputs: q_valid=0, q_inst=0, q_pc=0, kernel=RESET_VEC[WIDTH-1].

Kernel mode:
- kernel = q_valid ? q_pc[WIDTH-1] : fpc[WIDTH-1].
- Combinational, no added latency.

Per-cycle event priority: exc > irq_taken > redirect > sequential.
- irq_taken = irq & ~kernel. irq is ignored while in kernel mode; it stays pending because it is level-sensitive.
- exc: flush queue (count=0), fpc<=EXC_VEC, epc<=(q_valid ? q_pc : fpc). Accepted in either mode.
- irq_taken: flush queue, fpc<=IRQ_VEC, epc<=(q_valid ? q_pc : fpc). epc is the oldest unexecuted instruction.
- redirect: flush queue, fpc<={kernel & redirect_pc[WIDTH-1], redirect_pc[WIDTH-2:2], 2'b00}.
  - In user mode a redirect cannot set the kernel bit.
  - Low two bits are always cleared.
- In a flush cycle, deq and any fetch push are discarded. The new fpc is presented on imem_addr the next cycle.

Sequential fetch (no flush event):
- push = imem_valid & (count<DEPTH | (count==DEPTH & deq)).
- On push: entry <= {fpc, imem_data}, fpc[WIDTH-2:0] <= fpc[WIDTH-2:0]+4.
  - The bit-(WIDTH-2) carry wraps modulo 2^(WIDTH-1).
  - fpc[WIDTH-1] is held.
- imem_valid=0: fpc holds, no push.
- pop = deq & q_valid. deq while empty is ignored.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.

Latency:
- Instruction at fpc appears at q_pc/q_inst one cycle after a push.
- First q_valid=1 on the 1st rising edge after reset release, given imem_valid=1.

Throughput:
- 1 instruction/cycle with continuous imem_valid and deq.

Full:
- count==DEPTH & ~deq: fetch stalls, fpc and imem_addr stable.

Outputs q_inst/q_pc:
- Registered queue head; 0 when empty.

Test Plan:
- Reset release, imem_valid=1, deq=0 -> q_pc=0x80000000 after 1 edge; count reaches 4 after 4 edges; then imem_addr holds 0x00000010 and count stays 4.
- Full queue, deq=1 every cycle, imem_valid=1 -> count stays 4; q_pc advances +4 per cycle; no entry lost or duplicated (check q_inst sequence against ROM).
- User mode, head q_pc=0x00000040, irq=1 -> next cycle count=0, imem_addr=0x00000004, epc=0x00000040, kernel=1; irq still 1 -> no re-entry until a redirect to a user address.
- User mode, redirect=1 with redirect_pc=0x80001237 -> fpc=0x00001234 (kernel bit blocked, low bits cleared); kernel mode, same redirect -> fpc=0x80001234.
- Same cycle exc=1, irq=1, redirect=1, deq=1 -> exc wins: fpc=EXC_VEC, count=0, epc=old q_pc.
- imem_valid toggling 1,0,1 -> exactly 2 entries pushed, fpc advances by 8 total. Assert reset low mid-stream -> immediately count=0, q_valid=0, epc=0, imem_addr=0x00000000.
